// File: rtl/hazard_scoreboard_if.sv
// Issue / bypass bundle between DECODE (master) and hazard_scoreboard (slave).
// stall_cnt and CNT_W exist only when HAZARD_STATS_EN is defined.
interface hazard_scoreboard_if #(
  parameter int unsigned RA_W    = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned LAT_W   = 4
`ifdef HAZARD_STATS_EN
  ,
  parameter int unsigned CNT_W   = 32
`endif
) ();
  localparam int unsigned NRegs = 1 << RA_W;

  logic                      iss_valid;
  logic                      iss_wr;
  logic [RA_W-1:0]           iss_rd;
  logic [LAT_W-1:0]          iss_lat;
  logic [NUM_SRC*RA_W-1:0]   iss_src;
  logic                      kill;
  logic                      stall;
  logic                      iss_accept;
  logic [2*NUM_SRC-1:0]      byp_sel;
  logic [NRegs-1:0]          busy_vec;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0]          stall_cnt;
`endif

`ifdef HAZARD_STATS_EN
  modport master (
    output iss_valid, iss_wr, iss_rd, iss_lat, iss_src, kill,
    input  stall, iss_accept, byp_sel, busy_vec, stall_cnt
  );
  modport slave (
    input  iss_valid, iss_wr, iss_rd, iss_lat, iss_src, kill,
    output stall, iss_accept, byp_sel, busy_vec, stall_cnt
  );
`else
  modport master (
    output iss_valid, iss_wr, iss_rd, iss_lat, iss_src, kill,
    input  stall, iss_accept, byp_sel, busy_vec
  );
  modport slave (
    input  iss_valid, iss_wr, iss_rd, iss_lat, iss_src, kill,
    output stall, iss_accept, byp_sel, busy_vec
  );
`endif

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: RAW/WAW issue stall, registered EXEC bypass selects,
// single-level undo for kill. Define HAZARD_STATS_EN to add the saturating stall counter.
module hazard_scoreboard #(
  parameter int unsigned RA_W    = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned MAX_LAT = 8,
  parameter int unsigned LAT_W   = $clog2(MAX_LAT + 1)
`ifdef HAZARD_STATS_EN
  ,
  parameter int unsigned CNT_W   = 32
`endif
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  hazard_scoreboard_if.slave sb_io
);

  localparam int unsigned NRegs = 1 << RA_W;

  typedef logic [LAT_W-1:0] lat_t;

  function automatic lat_t dec_sat(input lat_t v);
    return (v == '0) ? '0 : v - lat_t'(1);
  endfunction

  lat_t                 cnt_q [NRegs];
  lat_t                 cnt_d [NRegs];
  logic                 u_vld_q, u_vld_d;
  logic [RA_W-1:0]      u_rd_q, u_rd_d;
  lat_t                 u_prev_q, u_prev_d;
  logic [2*NUM_SRC-1:0] byp_sel_q, byp_sel_d;

  logic [2*NUM_SRC-1:0] sel_calc;
  lat_t                 src_cnt [NUM_SRC];
  lat_t                 eff_lat;
  logic                 raw, waw, wr_track, stall, accept;

  always_comb begin
    if (sb_io.iss_lat == '0) begin
      eff_lat = lat_t'(1);
    end else if (sb_io.iss_lat > lat_t'(MAX_LAT)) begin
      eff_lat = lat_t'(MAX_LAT);
    end else begin
      eff_lat = sb_io.iss_lat;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_cnt[i] = cnt_q[sb_io.iss_src[i*RA_W +: RA_W]];
    end
  end

  // Count 2 means the producer is in MEM next cycle, count 1 means WB.
  always_comb begin
    raw      = 1'b0;
    sel_calc = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_cnt[i] > lat_t'(2)) begin
        raw = 1'b1;
      end else if (src_cnt[i] == lat_t'(2)) begin
        sel_calc[2*i +: 2] = 2'b10;
      end else if (src_cnt[i] == lat_t'(1)) begin
        sel_calc[2*i +: 2] = 2'b01;
      end
    end
  end

  assign wr_track = sb_io.iss_wr && (sb_io.iss_rd != '0);
  assign waw      = wr_track && (cnt_q[sb_io.iss_rd] > eff_lat);
  assign stall    = sb_io.iss_valid && (raw || waw);
  assign accept   = sb_io.iss_valid && !stall && !sb_io.kill;

  always_comb begin
    u_vld_d   = 1'b0;
    u_rd_d    = u_rd_q;
    u_prev_d  = u_prev_q;
    byp_sel_d = '0;
    for (int r = 0; r < NRegs; r++) begin
      cnt_d[r] = dec_sat(cnt_q[r]);
    end
    if (sb_io.kill) begin
      // Restore the older producer to where its own countdown would be now.
      if (u_vld_q) begin
        cnt_d[u_rd_q] = dec_sat(u_prev_q);
      end
    end else if (accept) begin
      byp_sel_d = sel_calc;
      if (wr_track) begin
        cnt_d[sb_io.iss_rd] = eff_lat;
        u_vld_d             = 1'b1;
        u_rd_d              = sb_io.iss_rd;
        u_prev_d            = dec_sat(cnt_q[sb_io.iss_rd]);
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int r = 0; r < NRegs; r++) begin
        cnt_q[r] <= '0;
      end
      u_vld_q   <= 1'b0;
      u_rd_q    <= '0;
      u_prev_q  <= '0;
      byp_sel_q <= '0;
    end else begin
      for (int r = 0; r < NRegs; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      u_vld_q   <= u_vld_d;
      u_rd_q    <= u_rd_d;
      u_prev_q  <= u_prev_d;
      byp_sel_q <= byp_sel_d;
    end
  end

  assign sb_io.stall      = stall;
  assign sb_io.iss_accept = accept;
  assign sb_io.byp_sel    = byp_sel_q;

  always_comb begin
    for (int r = 0; r < NRegs; r++) begin
      sb_io.busy_vec[r] = (cnt_q[r] != '0);
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb_io.stall_cnt = stall_cnt_q;
`endif

endmodule
